// File: rtl/neopixel_strip_driver.sv
// -----------------------------------------------------------------------------
// neopixel_strip_driver
//
// Parametrised WS2812 strip driver. A NUM_PIXELS x 24-bit frame buffer is
// written one pixel per load while idle. On go, every pixel is scaled by a
// global brightness (sampled once per frame) and sent GRB, MSB first, on a
// single data line. A latch gap follows. With AUTO_REFRESH set, the frame is
// re-sent continuously until reset.
//
// Ports
//   CLOCK_50       in   1      system clock, all logic on rising edge
//   reset          in   1      synchronous, active-high
//   pixel          in   IDX_W  buffer index for load
//   red/green/blue in   8      colour written on load
//   brightness     in   8      global scale, sampled at frame start
//   load           in   1      write {red,green,blue} to buffer[pixel]
//   go             in   1      request one frame transmission
//   neopixel_data  out  1      serial WS2812 line
//   ready          out  1      high while idle (load/go accepted)
// -----------------------------------------------------------------------------
module neopixel_strip_driver #(
    parameter int NUM_PIXELS   = 8,
    parameter int T0H_CYCLES   = 20,
    parameter int T1H_CYCLES   = 40,
    parameter int BIT_CYCLES   = 63,
    parameter int RESET_CYCLES = 3000,
    parameter int AUTO_REFRESH = 0,
    localparam int IDX_W = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic [IDX_W-1:0] pixel,
    input  logic [7:0]       red,
    input  logic [7:0]       green,
    input  logic [7:0]       blue,
    input  logic [7:0]       brightness,
    input  logic             load,
    input  logic             go,
    output logic             neopixel_data,
    output logic             ready
);

    // One counter serves both the per-bit timer and the latch-gap timer.
    localparam int CNT_MAX = (RESET_CYCLES > BIT_CYCLES) ? RESET_CYCLES : BIT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] LP_T0H_LAST = CNT_W'(T0H_CYCLES - 1);
    localparam logic [CNT_W-1:0] LP_T1H_LAST = CNT_W'(T1H_CYCLES - 1);
    localparam logic [CNT_W-1:0] LP_BIT_LAST = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LP_GAP_LAST = CNT_W'(RESET_CYCLES - 1);

    localparam logic [IDX_W:0]   LP_NUM_PIX  = (IDX_W + 1)'(NUM_PIXELS);
    localparam logic [IDX_W-1:0] LP_LAST_PIX = IDX_W'(NUM_PIXELS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_BIT_HIGH,
        S_BIT_LOW,
        S_GAP
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [23:0]      r_buf [NUM_PIXELS];   // stored as {r, g, b}
    logic [23:0]      r_shift;              // word being sent, {g', r', b'}
    logic [23:0]      r_next_word;          // scaled word of the following pixel
    logic [7:0]       r_bright;
    logic [CNT_W-1:0] r_cnt;
    logic [4:0]       r_bit;
    logic [IDX_W-1:0] r_pix;
    logic             r_data;
    logic             r_ready;

    logic             w_last_pix;
    logic [IDX_W-1:0] w_next_idx;
    logic [23:0]      w_scale_src;
    logic [7:0]       w_scale_b;
    logic [23:0]      w_scaled;
    logic [CNT_W-1:0] w_high_last;
    logic             w_bit_done;
    logic             w_gap_done;
    logic             w_load_ok;

    // out = (c * (b + 1)) >> 8 : b = 255 passes c through, b = 0 blanks it.
    function automatic logic [7:0] scale8(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] prod;
        prod = 16'(c) * (16'(b) + 16'd1);
        return prod[15:8];
    endfunction

    assign w_last_pix = (r_pix == LP_LAST_PIX);
    assign w_next_idx = w_last_pix ? '0 : r_pix + IDX_W'(1);

    // A single scaler is shared: in FETCH it produces pixel 0 from the live
    // brightness input; while bits are streaming it prepares the next pixel
    // from the latched brightness, so pixel boundaries need no extra cycle.
    assign w_scale_src = (r_state == S_FETCH) ? r_buf[0]   : r_buf[w_next_idx];
    assign w_scale_b   = (r_state == S_FETCH) ? brightness : r_bright;
    assign w_scaled    = {scale8(w_scale_src[15:8],  w_scale_b),
                          scale8(w_scale_src[23:16], w_scale_b),
                          scale8(w_scale_src[7:0],   w_scale_b)};

    assign w_high_last = r_shift[23] ? LP_T1H_LAST : LP_T0H_LAST;

    // Out-of-range indices are dropped rather than aliased onto a real pixel.
    assign w_load_ok = (r_state == S_IDLE) && load && ({1'b0, pixel} < LP_NUM_PIX);

    // Next-state logic.
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        w_state_next = r_state;
        w_bit_done   = 1'b0;
        w_gap_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (go) w_state_next = S_FETCH;
            end
            S_FETCH: begin
                w_state_next = S_BIT_HIGH;
            end
            S_BIT_HIGH: begin
                if (r_cnt == w_high_last) w_state_next = S_BIT_LOW;
            end
            S_BIT_LOW: begin
                // The counter runs across both phases, so the bit always ends
                // at BIT_CYCLES regardless of its high time.
                if (r_cnt == LP_BIT_LAST) begin
                    w_bit_done = 1'b1;
                    if (r_bit == 5'd23 && w_last_pix) w_state_next = S_GAP;
                    else                              w_state_next = S_BIT_HIGH;
                end
            end
            S_GAP: begin
                if (r_cnt == LP_GAP_LAST) begin
                    w_gap_done   = 1'b1;
                    w_state_next = (AUTO_REFRESH != 0) ? S_FETCH : S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State register, datapath and frame buffer.
    always_ff @(posedge CLOCK_50) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the values from before this edge, independent of order.
        if (reset) begin
            r_state     <= S_IDLE;
            r_data      <= 1'b0;
            r_ready     <= 1'b1;
            r_bright    <= 8'hFF;
            r_cnt       <= '0;
            r_bit       <= '0;
            r_pix       <= '0;
            r_shift     <= '0;
            r_next_word <= '0;
            // NOTE: the buffer is a register array rather than a RAM, because
            // reset must blank every pixel; a RAM macro could not be cleared
            // in one cycle.
            for (int i = 0; i < NUM_PIXELS; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_state <= w_state_next;
            // Outputs are registered from the next state so they change on
            // the same edge as the state and never glitch on the pin.
            r_data  <= (w_state_next == S_BIT_HIGH);
            r_ready <= (w_state_next == S_IDLE);

            if (w_load_ok) begin
                r_buf[pixel] <= {red, green, blue};
            end

            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    r_bit <= '0;
                    r_pix <= '0;
                end
                S_FETCH: begin
                    r_bright <= brightness;
                    r_shift  <= w_scaled;
                    r_cnt    <= '0;
                    r_bit    <= '0;
                    r_pix    <= '0;
                end
                S_BIT_HIGH: begin
                    r_cnt       <= r_cnt + CNT_W'(1);
                    r_next_word <= w_scaled;
                end
                S_BIT_LOW: begin
                    r_next_word <= w_scaled;
                    if (w_bit_done) begin
                        r_cnt <= '0;
                        if (r_bit == 5'd23) begin
                            r_bit   <= '0;
                            r_pix   <= w_next_idx;
                            r_shift <= r_next_word;
                        end else begin
                            r_bit   <= r_bit + 5'd1;
                            r_shift <= {r_shift[22:0], 1'b0};
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_GAP: begin
                    if (w_gap_done) r_cnt <= '0;
                    else            r_cnt <= r_cnt + CNT_W'(1);
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign neopixel_data = r_data;
    assign ready         = r_ready;

endmodule
